// File: rtl/piso_shift_register.sv
// Parallel-in / serial-out word shifter.
// A block of LENGTH words is captured in one load transfer and emitted word 0
// first, one word per out transfer. The last-word cycle can hand off directly
// to the next block, so a source holding load_valid high gets a gapless stream.
module piso_shift_register #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH*LENGTH-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state;
  logic [WIDTH*LENGTH-1:0] shift_buf;
  logic [CW-1:0]           cnt;

  // Word 0 of the buffer is the serial output; the buffer is zeroed whenever
  // no block is in flight, so data_out reads 0 in IDLE.
  assign data_out = shift_buf[WIDTH-1:0];

  // A load is accepted when idle, or on the cycle the final word of the current
  // block is being taken by the sink. Never during reset.
  always_comb begin
    load_ready = 1'b0;
    if (!reset) begin
      load_ready = (state == IDLE) ||
                   ((state == SHIFT) && out_ready && (cnt == LAST));
    end
  end

  // Control FSM plus word buffer: capture, shift-down with zero fill, handoff.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_buf <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shift_buf <= load_data;
            cnt       <= '0;
            state     <= SHIFT;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (cnt != LAST) begin
              shift_buf <= {{WIDTH{1'b0}}, shift_buf[WIDTH*LENGTH-1:WIDTH]};
              cnt       <= cnt + ONE;
              out_last  <= ((cnt + ONE) == LAST);
            end else if (load_valid) begin
              shift_buf <= load_data;
              cnt       <= '0;
              out_last  <= 1'b0;
            end else begin
              state     <= IDLE;
              shift_buf <= '0;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          shift_buf <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: directed scenarios plus random traffic, with a
// queue-based model of the words still owed to the sink.
module tb_piso_shift_register;

  localparam int WIDTH  = 8;
  localparam int LENGTH = 4;

  logic                    clock;
  logic                    reset;
  logic [WIDTH*LENGTH-1:0] load_data;
  logic                    load_valid;
  logic                    load_ready;
  logic [WIDTH-1:0]        data_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  piso_shift_register #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: words still to be delivered, in order, plus a log of delivered words.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] mlog[$];
  bit               mlast[$];
  bit               chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_load_ready();
    return !reset && ((q.size() == 0) || (out_ready && q.size() == 1));
  endfunction

  // Model update on every rising edge, using the inputs present at the edge.
  initial begin
    forever begin
      @(posedge clock);
      if (reset === 1'b1) begin
        q.delete();
        chk_en = 1'b1;
      end else begin
        bit lr;
        lr = exp_load_ready();
        if (q.size() != 0 && out_ready) begin
          mlog.push_back(q[0]);
          mlast.push_back(q.size() == 1);
          void'(q.pop_front());
        end
        if (load_valid && lr) begin
          for (int k = 0; k < LENGTH; k++) q.push_back(load_data[k*WIDTH +: WIDTH]);
        end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("data_out", 32'(data_out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        check("out_last", 32'(out_last), 32'(q.size() == 1));
        check("load_ready", 32'(load_ready), 32'(exp_load_ready()));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_log(input string name, input logic [WIDTH-1:0] exp[]);
    check({name, "_len"}, 32'(mlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_w%0d", name, i), (i < mlog.size()) ? 32'(mlog[i]) : 32'hx, 32'(exp[i]));
      check($sformatf("%s_last%0d", name, i), (i < mlast.size()) ? 32'(mlast[i]) : 32'hx,
            32'((i % LENGTH) == LENGTH - 1));
    end
    mlog.delete();
    mlast.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nrdy;
    int rdy_at;
    logic [1:0] pat[6];
    reset      = 1'b1;
    load_data  = '0;
    load_valid = 1'b0;
    out_ready  = 1'b0;

    // 1: reset for two cycles
    step();
    step();
    reset = 1'b0;
    #1;
    check("t1_data_out", 32'(data_out), 32'h0);
    check("t1_out_valid", 32'(out_valid), 32'h0);
    check("t1_out_last", 32'(out_last), 32'h0);
    check("t1_load_ready", 32'(load_ready), 32'h1);
    mlog.delete();
    mlast.delete();

    // 2: single block, sink always ready
    load_data = 32'h44332211; load_valid = 1'b1; out_ready = 1'b1;
    step();
    load_valid = 1'b0;
    check("t2_first", 32'(data_out), 32'h11);
    repeat (4) step();
    check("t2_idle", 32'(out_valid), 32'h0);
    check_log("t2", '{8'h11, 8'h22, 8'h33, 8'h44});

    // 3: backpressure pattern 1,0,0,1,1,1
    pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i][0];
      if (i == 2) check("t3_hold", 32'(data_out), 32'h22);
      step();
    end
    out_ready = 1'b1;
    check("t3_idle", 32'(out_valid), 32'h0);
    check_log("t3", '{8'h11, 8'h22, 8'h33, 8'h44});

    // 4: back-to-back blocks with load_valid held
    load_data = 32'h44332211; load_valid = 1'b1;
    step();
    load_data = 32'h88776655;
    nrdy = 0; rdy_at = -1;
    for (int i = 0; i < 8; i++) begin
      bit acc;
      acc = load_ready && load_valid;
      if (i < 7 && load_ready) begin nrdy++; rdy_at = i; end
      step();
      if (acc) load_valid = 1'b0;
    end
    check("t4_nrdy", 32'(nrdy), 32'd1);
    check("t4_rdy_at", 32'(rdy_at), 32'd3);
    check("t4_idle", 32'(out_valid), 32'h0);
    check_log("t4", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});

    // 5: load_valid mid-block is not accepted
    load_data = 32'h44332211; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    check("t5_at22", 32'(data_out), 32'h22);
    load_data = 32'h88776655; load_valid = 1'b1;
    #1;
    check("t5_rdy22", 32'(load_ready), 32'h0);
    step();
    check("t5_rdy33", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    step();
    step();
    check("t5_idle", 32'(out_valid), 32'h0);
    check_log("t5", '{8'h11, 8'h22, 8'h33, 8'h44});

    // 6: reset mid-block, then a fresh load
    load_data = 32'h44332211; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("t6_rdy_in_reset", 32'(load_ready), 32'h0);
    step();
    reset = 1'b0;
    check("t6_valid", 32'(out_valid), 32'h0);
    check("t6_data", 32'(data_out), 32'h0);
    mlog.delete();
    mlast.delete();
    load_data = 32'hDDCCBBAA; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (4) step();
    check_log("t6", '{8'hAA, 8'hBB, 8'hCC, 8'hDD});

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      load_valid = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      load_data  = $urandom;
      step();
    end
    reset = 1'b0; load_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
